// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory read port, decode valid/ready handshake and
// execute redirect. fetch_count exists only when FETCH_COUNT_EN is defined.
interface fetch_unit_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;

    modport master (
        output mem_addr, mem_rstrb, instr, instr_pc, instr_valid, fetch_count,
        input  mem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  mem_addr, mem_rstrb, instr, instr_pc, instr_valid, fetch_count,
        output mem_rdata, instr_ready, redirect, redirect_pc
    );
`else
    modport master (
        output mem_addr, mem_rstrb, instr, instr_pc, instr_valid,
        input  mem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  mem_addr, mem_rstrb, instr, instr_pc, instr_valid,
        output mem_rdata, instr_ready, redirect, redirect_pc
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, strobes a one-cycle-latency
// instruction memory, presents fetched words to decode over valid/ready,
// and accepts redirects from execute (dropping any in-flight read).
// Optional macro FETCH_COUNT_EN adds a 32-bit completed-handshake counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        valid_q;

    logic [31:0] pc_next_d;
    logic        handshake_d;
    logic        rstrb_d;

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q;
`endif

    assign pc_next_d   = pc_q + 32'd4;
    assign handshake_d = valid_q & bus.instr_ready;

    // Read strobe: issued in S_FETCH, or from S_HOLD as the handshake completes;
    // suppressed by a redirect or reset so no read at a stale PC is started.
    always_comb begin
        rstrb_d = 1'b0;
        if (!reset && !bus.redirect) begin
            if (state_q == S_FETCH) begin
                rstrb_d = 1'b1;
            end else if (state_q == S_HOLD && bus.instr_ready) begin
                rstrb_d = 1'b1;
            end
        end
    end

    assign bus.mem_addr    = pc_q;
    assign bus.mem_rstrb   = rstrb_d;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
`ifdef FETCH_COUNT_EN
    assign bus.fetch_count = count_q;
`endif

    // Fetch FSM with PC, captured instruction and valid flag as registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
`ifdef FETCH_COUNT_EN
            count_q    <= '0;
`endif
        end else begin
`ifdef FETCH_COUNT_EN
            // A handshake coinciding with a redirect still counts.
            if (handshake_d) begin
                count_q <= count_q + 32'd1;
            end
`endif
            if (bus.redirect) begin
                // Redirect wins in every state; data returning this cycle is dropped.
                pc_q    <= bus.redirect_pc & 32'hFFFF_FFFC;
                valid_q <= 1'b0;
                state_q <= S_FETCH;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        instr_q    <= bus.mem_rdata;
                        instr_pc_q <= pc_q;
                        pc_q       <= pc_next_d;
                        valid_q    <= 1'b1;
                        state_q    <= S_HOLD;
                    end
                    S_HOLD: begin
                        // PC already points at the next word, so the strobe
                        // issued with the handshake reads it directly.
                        if (bus.instr_ready) begin
                            valid_q <= 1'b0;
                            state_q <= S_WAIT;
                        end
                    end
                    default: begin
                        state_q <= S_FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus with hand-computed expectations
// pushed into scoreboards; monitors pop and compare on each handshake and
// each memory strobe. A second instance checks RESET_PC = 32'hFFFF_FFFC.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int vectors    = 0;
    int miscompares = 0;

    item_t       exp_q[$];
    logic [31:0] strb_q[$];
    item_t       exp2_q[$];
    logic [31:0] strb2_q[$];

    // Instruction memory contents.
    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0000_0000: memword = 32'h0000_0513;
            32'h0000_0004: memword = 32'h0015_0513;
            32'h0000_0008: memword = 32'h0100_006F;
            32'h0000_000C: memword = 32'h0010_0073;
            default:       memword = 32'hC0DE_0000 | {16'h0000, a[15:0]};
        endcase
    endfunction

    // Memories: data registered one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rstrb) bus.mem_rdata <= memword(bus.mem_addr);
        if (bus2.mem_rstrb) bus2.mem_rdata <= memword(bus2.mem_addr);
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the main instance: every handshake and every strobe must be expected.
    always @(negedge clk) begin : mon1
        item_t e;
        logic [31:0] a;
        if (!reset) begin
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_handshake: got pc %h, expected none", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check32("hs_instr", bus.instr, e.instr);
                    check32("hs_instr_pc", bus.instr_pc, e.pc);
                end
            end
            if (bus.mem_rstrb) begin
                if (strb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got addr %h, expected none", bus.mem_addr);
                end else begin
                    a = strb_q.pop_front();
                    check32("strobe_addr", bus.mem_addr, a);
                end
            end
        end
    end

    // Monitor for the wrap instance: checks only its first few events.
    always @(negedge clk) begin : mon2
        item_t e;
        logic [31:0] a;
        if (!reset) begin
            if (bus2.instr_valid && bus2.instr_ready && exp2_q.size() != 0) begin
                e = exp2_q.pop_front();
                check32("wrap_instr", bus2.instr, e.instr);
                check32("wrap_instr_pc", bus2.instr_pc, e.pc);
            end
            if (bus2.mem_rstrb && strb2_q.size() != 0) begin
                a = strb2_q.pop_front();
                check32("wrap_strobe_addr", bus2.mem_addr, a);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.instr_ready  = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus2.instr_ready = 1'b1;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = '0;

        strb2_q.push_back(32'hFFFF_FFFC);
        strb2_q.push_back(32'h0000_0000);
        exp2_q.push_back('{instr: 32'hC0DE_FFFC, pc: 32'hFFFF_FFFC});
        exp2_q.push_back('{instr: 32'h0000_0513, pc: 32'h0000_0000});

        repeat (2) tick();
        check32("rst_instr", bus.instr, 32'h0);
        check32("rst_instr_pc", bus.instr_pc, 32'h0);
        check32("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        check32("rst_rstrb", {31'h0, bus.mem_rstrb}, 32'h0);
        check32("rst_addr", bus.mem_addr, 32'h0);
        check32("rst_addr_wrap", bus2.mem_addr, 32'hFFFF_FFFC);
`ifdef FETCH_COUNT_EN
        check32("rst_count", bus.fetch_count, 32'h0);
`endif

        // Sequential fetch with ready high, then a 5-cycle stall.
        strb_q.push_back(32'h0);
        strb_q.push_back(32'h4);
        strb_q.push_back(32'h8);
        strb_q.push_back(32'hC);
        strb_q.push_back(32'h10);
        exp_q.push_back('{instr: 32'h0000_0513, pc: 32'h0});
        exp_q.push_back('{instr: 32'h0015_0513, pc: 32'h4});
        exp_q.push_back('{instr: 32'h0100_006F, pc: 32'h8});
        exp_q.push_back('{instr: 32'h0010_0073, pc: 32'hC});

        reset = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        check32("c0_valid", {31'h0, bus.instr_valid}, 32'h0);
        check32("c0_rstrb", {31'h0, bus.mem_rstrb}, 32'h1);
        tick();
        check32("c1_valid", {31'h0, bus.instr_valid}, 32'h0);
        tick();
        check32("first_valid", {31'h0, bus.instr_valid}, 32'h1);
        check32("first_instr_pc", bus.instr_pc, 32'h0);
        repeat (6) tick();
        // c8: holding word at 0xC
        bus.instr_ready = 1'b0;
        check32("c8_valid", {31'h0, bus.instr_valid}, 32'h1);
`ifdef FETCH_COUNT_EN
        check32("c8_count", bus.fetch_count, 32'd3);
`endif
        for (int i = 0; i < 5; i++) begin
            #1;
            check32("stall_instr", bus.instr, 32'h0010_0073);
            check32("stall_instr_pc", bus.instr_pc, 32'hC);
            check32("stall_addr", bus.mem_addr, 32'h10);
            check32("stall_rstrb", {31'h0, bus.mem_rstrb}, 32'h0);
            tick();
        end
        bus.instr_ready = 1'b1;
        #1;
        check32("release_rstrb", {31'h0, bus.mem_rstrb}, 32'h1);
        check32("release_addr", bus.mem_addr, 32'h10);

        // Redirects: discard 0x10 and 0x8 reads, then redirect during a handshake.
        strb_q.push_back(32'h8);
        strb_q.push_back(32'h14);
        strb_q.push_back(32'h14);
        strb_q.push_back(32'h18);
        exp_q.push_back('{instr: 32'hC0DE_0014, pc: 32'h14});
        exp_q.push_back('{instr: 32'hC0DE_0014, pc: 32'h14});
        tick();                                  // c14: S_WAIT for 0x10
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h8;
        tick();                                  // c15
        bus.redirect = 1'b0;
        #1;
        check32("redir8_addr", bus.mem_addr, 32'h8);
        check32("redir8_rstrb", {31'h0, bus.mem_rstrb}, 32'h1);
        tick();                                  // c16: S_WAIT for 0x8
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h14;
        #1;
        check32("redir14_rstrb", {31'h0, bus.mem_rstrb}, 32'h0);
        tick();                                  // c17
        bus.redirect = 1'b0;
        #1;
        check32("redir14_addr", bus.mem_addr, 32'h14);
        check32("redir14_valid", {31'h0, bus.instr_valid}, 32'h0);
        tick();                                  // c18
        check32("c18_valid", {31'h0, bus.instr_valid}, 32'h0);
        tick();                                  // c19: holding 0x14
        check32("c19_instr_pc", bus.instr_pc, 32'h14);
        check32("c19_instr", bus.instr, 32'hC0DE_0014);
`ifdef FETCH_COUNT_EN
        check32("c19_count", bus.fetch_count, 32'd4);
`endif
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h17;
        #1;
        check32("redir_hs_rstrb", {31'h0, bus.mem_rstrb}, 32'h0);
        tick();                                  // c20
        bus.redirect = 1'b0;
        #1;
`ifdef FETCH_COUNT_EN
        check32("redir_hs_count", bus.fetch_count, 32'd5);
`endif
        check32("redir17_addr", bus.mem_addr, 32'h14);
        check32("redir17_rstrb", {31'h0, bus.mem_rstrb}, 32'h1);
        tick();                                  // c21
        tick();                                  // c22: handshake, strobe 0x18
        check32("c22_addr", bus.mem_addr, 32'h18);
        tick();                                  // c23: S_WAIT for 0x18
`ifdef FETCH_COUNT_EN
        check32("pre_reset_count", bus.fetch_count, 32'd6);
`endif

        // Asynchronous reset mid-read.
        reset = 1'b1;
        #1;
        check32("mid_rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        check32("mid_rst_rstrb", {31'h0, bus.mem_rstrb}, 32'h0);
        check32("mid_rst_addr", bus.mem_addr, 32'h0);
`ifdef FETCH_COUNT_EN
        check32("mid_rst_count", bus.fetch_count, 32'h0);
`endif
        tick();
        tick();
        strb_q.push_back(32'h0);
        strb_q.push_back(32'h4);
        exp_q.push_back('{instr: 32'h0000_0513, pc: 32'h0});
        reset = 1'b0;
        #1;
        check32("refetch_addr", bus.mem_addr, 32'h0);
        check32("refetch_rstrb", {31'h0, bus.mem_rstrb}, 32'h1);
        tick();
        check32("refetch_c1_valid", {31'h0, bus.instr_valid}, 32'h0);
        tick();
        check32("refetch_valid", {31'h0, bus.instr_valid}, 32'h1);
        check32("refetch_instr", bus.instr, 32'h0000_0513);
        tick();
        tick();                                  // holding word at 0x4
        bus.instr_ready = 1'b0;
        #1;
        check32("park_valid", {31'h0, bus.instr_valid}, 32'h1);
        check32("park_instr", bus.instr, 32'h0015_0513);
        check32("park_instr_pc", bus.instr_pc, 32'h4);
        check32("park_rstrb", {31'h0, bus.mem_rstrb}, 32'h0);
        tick();
        tick();

        check32("pending_handshakes", exp_q.size(), 32'd0);
        check32("pending_strobes", strb_q.size(), 32'd0);
        check32("wrap_pending_handshakes", exp2_q.size(), 32'd0);
        check32("wrap_pending_strobes", strb2_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Drives mem_addr/mem_rstrb to the memory. The memory returns mem_rdata registered one cycle after the strobe.
- Presents each fetched word to decode over a valid/ready handshake.
- Holds the PC, increments it sequentially, and accepts redirects (jump/branch/CALL/RET targets) from execute, discarding any in-flight read.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- mem_addr  output  32  byte address of the word being read; equals PC
- mem_rstrb  output  1  read strobe; memory samples mem_addr on the same edge
- mem_rdata  input  32  read data, valid the cycle after mem_rstrb
- instr  output  32  fetched instruction word
- instr_pc  output  32  byte address instr was fetched from
- instr_valid  output  1  instr/instr_pc valid
- instr_ready  input  1  decode accepts instr this cycle
- redirect  input  1  single-cycle pulse: load new PC
- redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 00
- fetch_count  output  32  present only with FETCH_COUNT_EN

Behaviour:
- Reset (async, while reset=1):
  - PC=RESET_PC, state=S_FETCH.
  - instr=0, instr_pc=0, instr_valid=0.
  - mem_rstrb forced 0.
- Combinational outputs:
  - mem_addr = PC.
  - mem_rstrb = 1 in S_FETCH, or in S_HOLD when instr_ready=1. Forced 0 when redirect=1 or reset=1.
- States:
  - S_FETCH: strobe at PC -> S_WAIT.
  - S_WAIT: mem_rdata valid.
    - Capture instr<=mem_rdata, instr_pc<=PC, PC<=PC+4, instr_valid<=1 -> S_HOLD.
  - S_HOLD: instr_valid=1, outputs held stable.
    - instr_ready=0: stay in S_HOLD.
    - instr_ready=1: handshake completes. The next read is strobed in the same cycle at the already-incremented PC -> S_WAIT. instr_valid<=0 on that edge.
- Latency:
  - First instr_valid 2 cycles after reset release.
  - Sustained throughput: one instruction per 2 cycles with instr_ready held high.
- Redirect (any state): PC<=redirect_pc & ~3, instr_valid<=0 -> S_FETCH.
  - A strobe issued the cycle before (data arriving in S_WAIT) is discarded, never presented.
  - Redirect beats a simultaneous handshake: the handshake still completes (decode consumed instr), but no new strobe is issued that cycle.
  - Back-to-back redirects: last one wins.
- Arithmetic: PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- No backpressure from memory: its data arrives exactly one cycle after the strobe.
- mem_rdata is ignored in all states except S_WAIT.
- Reset mid-operation: all state returns to reset values immediately. Data from a pending read is dropped.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined:
  - Adds output fetch_count, a 32-bit counter of completed handshakes (instr_valid & instr_ready).
  - Reset to 0; wraps modulo 2^32.
  - Counts handshakes that coincide with a redirect.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, instr_ready=1, memory words 0..3 = 0x00000513, 0x00150513, 0x0100006F, 0x00100073 -> mem_addr sequence 0,4,8,12.
  - instr_valid pulses every 2nd cycle with matching instr/instr_pc.
  - First valid exactly 2 cycles after release.
- instr_ready=0 for 5 cycles while instr_valid=1 -> instr, instr_pc and mem_addr stable, mem_rstrb=0.
  - Release ready -> strobe in the same cycle at the next PC.
- Redirect to 0x14 the cycle after the strobe at 0x8 -> word at 0x8 never presented; next mem_addr=0x14.
  - instr_pc of next valid = 0x14.
- Redirect with redirect_pc=0x17 in S_HOLD with instr_ready=1 -> mem_rstrb=0 that cycle, next fetch at 0x14.
  - With FETCH_COUNT_EN, fetch_count increments by 1.
- RESET_PC=32'hFFFF_FFFC -> first fetch at 0xFFFFFFFC, second at 0x0.
- Assert reset while in S_WAIT -> instr_valid=0 and mem_rstrb=0 immediately (async).
  - After release, refetch at RESET_PC.
  - fetch_count=0 when FETCH_COUNT_EN is defined.
